count_source: RTL
=================

# count_source

Free-running WIDTH-bit up/down counter that produces the `count` bus consumed by the overflow detector, and reports boundary crossings itself. It has a sticky overflow flag with an acknowledge handshake and a saturating count of boundary events. It sits upstream of the detector and is the source of every `count` value the detector samples.

## Interface

Parameters:
- `WIDTH`, 8: counter width.
- `EVT_W`, 4: width of the event counter.

Ports:
- `clk`, input, 1: single clock. Everything is sampled on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: step the counter this cycle.
- `up`, input, 1: direction. 1 counts up, 0 counts down.
- `sat_mode`, input, 1: 1 saturates at the boundary, 0 wraps.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, WIDTH: value to load.
- `ovf_ack`, input, 1: acknowledges and clears the pending overflow.
- `count`, output, WIDTH: registered counter value.
- `carry`, output, 1: registered one-cycle pulse per boundary event.
- `ovf_pending`, output, 1: sticky flag, set by an event and cleared by `ovf_ack`.
- `ovf_events`, output, EVT_W: events since the last ack, saturating at 2^EVT_W-1.

## Operation

- **Priority:** `load` beats `en`.
  - `load`=1: `count` takes `load_val` on the next edge. No event is raised, and `en`/`up` are ignored.
  - `en`=0 and `load`=0: `count` holds.
- **Boundary event:** raised when `en`=1, `load`=0, and either `up`=1 with `count`=MAX (all ones), or `up`=0 with `count`=0.
- **Wrap mode** (`sat_mode`=0):
  - MAX+1 becomes 0.
  - 0-1 becomes MAX.
  - All other steps are ±1, modulo 2^WIDTH.
- **Saturate mode** (`sat_mode`=1):
  - `count` holds at MAX or 0.
  - Every further attempted step beyond the boundary is a separate event.
- **Reporter FSM** has two states, OVF_CLEAR and OVF_PEND.
  - OVF_CLEAR: an event moves it to OVF_PEND.
  - OVF_PEND: `ovf_ack` without an event moves it to OVF_CLEAR.
  - OVF_PEND: `ovf_ack` in the same cycle as an event keeps it in OVF_PEND. The event wins.
  - `ovf_ack` in OVF_CLEAR is ignored.
  - `ovf_pending` = (state == OVF_PEND).
- **`ovf_events` update rules:**
  - Each event adds 1, saturating at all ones.
  - An ack with no event loads 0.
  - An ack together with an event loads 1.
- `sat_mode` and `up` may change on any cycle. They take effect on the cycle they are sampled.

## Timing

- **Reset:** `reset`=0 asynchronously forces the following, immediately and with no clock edge:
  - `count`=0
  - `carry`=0
  - `ovf_pending`=0
  - `ovf_events`=0
  - FSM = OVF_CLEAR
- **Release** is synchronous to the first rising edge after `reset` rises. That first edge is the first one at which inputs are sampled.
- **Count latency:** inputs sampled at edge N appear on `count` after edge N.
- **Event outputs:** an event sampled at edge N shows `carry`=1, `ovf_pending`=1 and the updated `ovf_events` after edge N, coincident with the wrapped or saturated `count`.
- **`carry`** is high exactly one cycle per event. Back-to-back events (saturate mode) keep it high on consecutive cycles.
- **Ack latency:** `ovf_ack` sampled at edge N clears `ovf_pending` after edge N.
- **Reset mid-operation** discards a pending flag and the event count. There is no partial update.

## Structure

- **Package `count_source_pkg`:**
  - `typedef enum logic {OVF_CLEAR, OVF_PEND} ovf_state_t`
  - default-width localparams
  - helper function `is_boundary(count, up)`
- **Sub-module `ovf_reporter`:**
  - Contains the FSM, `ovf_events` and `carry` register.
  - Inputs: `clk`, `reset`, `event`, `ovf_ack`.
  - Reusable by other event sources.
- **Top:** the counter datapath and event decode.

## Test plan

WIDTH=8, EVT_W=4.

1. **Reset and idle:** drive `reset`=0, then release with `en`=0 for 3 cycles → all outputs 0 throughout, and `count` stays 8'h00.
2. **Up wrap:** load 8'hFE, then `en`=1, `up`=1, `sat_mode`=0 → `count` goes FF, then 00. `carry` is high only in the 00 cycle. `ovf_pending`=1, `ovf_events`=1.
3. **Down wrap with load priority:** load 8'h01, then `en`=1, `up`=0 → 00, then FF with one event. Then `load`=1 with `load_val`=8'h00 and `en`=1 in the same cycle → `count`=00 and no event.
4. **Saturate:** `sat_mode`=1, load 8'hFF, `en`=1, `up`=1 for 3 cycles → `count` stays FF, `carry` is high 3 consecutive cycles, `ovf_events`=3. Continue for 20 cycles → `ovf_events` holds at 4'hF.
5. **Ack race:** with the flag pending, assert `ovf_ack` alone → `ovf_pending`=0, `ovf_events`=0. Then assert `ovf_ack` in the same cycle as an event → `ovf_pending`=1, `ovf_events`=1.
6. **Async reset mid-count:** at `count`=8'h80 with the flag pending, drop `reset` mid-cycle → `count`=0 and `ovf_pending`=0 before the next edge.

Source files
------------

// File: rtl/count_source_pkg.sv
// Shared types and helpers for the count source and its overflow reporter.
package count_source_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_EVT_W = 4;

  typedef enum logic {
    OVF_CLEAR = 1'b0,
    OVF_PEND  = 1'b1
  } ovf_state_t;

  // The count is passed zero-extended to 32 bits so one helper serves any WIDTH up to 32.
  function automatic logic is_boundary(input logic [31:0] count, input logic up,
                                       input int unsigned width);
    logic [31:0] max_val;
    max_val = 32'hFFFF_FFFF >> (32 - width);
    return up ? (count == max_val) : (count == '0);
  endfunction

endpackage

// File: rtl/ovf_reporter.sv
// Sticky overflow flag with acknowledge, saturating event count and a one-cycle carry pulse.
module ovf_reporter
  import count_source_pkg::*;
#(
  parameter int unsigned EVT_W = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt,
  input  logic             ovf_ack,
  output logic             carry,
  output logic             ovf_pending,
  output logic [EVT_W-1:0] ovf_events
);

  ovf_state_t state;
  logic       ack_live;

  // An ack only matters while a flag is pending; an event in the same cycle wins.
  assign ack_live    = ovf_ack && (state == OVF_PEND);
  assign ovf_pending = (state == OVF_PEND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= OVF_CLEAR;
      carry      <= 1'b0;
      ovf_events <= '0;
    end else begin
      carry <= evt;

      case (state)
        OVF_CLEAR: if (evt) state <= OVF_PEND;
        OVF_PEND:  if (ovf_ack && !evt) state <= OVF_CLEAR;
        default:   state <= OVF_CLEAR;
      endcase

      if (ack_live) begin
        ovf_events <= evt ? EVT_W'(1) : '0;
      end else if (evt && (ovf_events != '1)) begin
        ovf_events <= ovf_events + EVT_W'(1);
      end
    end
  end

endmodule

// File: rtl/count_source.sv
// Free-running up/down counter with wrap/saturate modes feeding the overflow reporter.
module count_source
  import count_source_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned EVT_W = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_ack,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             ovf_pending,
  output logic [EVT_W-1:0] ovf_events
);

  logic             boundary;
  logic [WIDTH-1:0] count_next;

  // Load masks the step, so a load never raises an event.
  assign boundary = en && !load && is_boundary(32'(count), up, WIDTH);

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      if (boundary && sat_mode) begin
        count_next = count;
      end else if (up) begin
        count_next = count + WIDTH'(1);
      end else begin
        count_next = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  ovf_reporter #(
    .EVT_W(EVT_W)
  ) u_reporter (
    .clk        (clk),
    .reset      (reset),
    .evt        (boundary),
    .ovf_ack    (ovf_ack),
    .carry      (carry),
    .ovf_pending(ovf_pending),
    .ovf_events (ovf_events)
  );

endmodule
